// File: rtl/mem_if_pkg.sv
// Shared definitions for the unified instruction/data memory responder:
// RV32I load/store funct3 codes, responder FSM states and request source.
package mem_if_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        SRC_IF,
        SRC_D
    } src_e;

endpackage

// File: rtl/unified_mem_responder_lane_align.sv
// Byte-lane steering for the unified memory: store byte enables and replicated
// write data, load lane extraction with sign/zero extension, and access legality.
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        err_o   = 1'b0;
        byte_v  = rword_i[{addr_lo_i, 3'b000} +: 8];
        half_v  = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

        if (we_i) begin
            // Store data is replicated across lanes so the byte enables alone select the target.
            case (funct3_i)
                F3_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_H: begin
                    err_o   = addr_lo_i[0];
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                F3_W: begin
                    err_o   = |addr_lo_i;
                    be_o    = 4'b1111;
                    wdata_o = wdata_i;
                end
                default: err_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B:  rdata_o = {{24{byte_v[7]}}, byte_v};
                F3_BU: rdata_o = {24'h0, byte_v};
                F3_H: begin
                    err_o   = addr_lo_i[0];
                    rdata_o = {{16{half_v[15]}}, half_v};
                end
                F3_HU: begin
                    err_o   = addr_lo_i[0];
                    rdata_o = {16'h0, half_v};
                end
                F3_W: begin
                    err_o   = |addr_lo_i;
                    rdata_o = rword_i;
                end
                default: err_o = 1'b1;
            endcase
        end

        if (err_o) begin
            be_o    = '0;
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Shared single-port instruction/data memory responder: arbitrates fetch and
// load/store initiators (data first), adds wait states, and answers with one-cycle acks.
module unified_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    src_e                src_q, src_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                if_ack_q, d_ack_q, d_err_q;
    logic [31:0]         if_rdata_q, d_rdata_q;

    logic                enter_resp;
    logic                mem_we;
    logic [ADDR_W-3:0]   acc_idx;
    logic [31:0]         rd_word;
    logic [3:0]          lane_be;
    logic [31:0]         lane_wdata;
    logic [31:0]         lane_rdata;
    logic                lane_err;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        addr_d  = addr_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    src_d   = d_req ? SRC_D : SRC_IF;
                    addr_d  = d_req ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                    we_d    = d_req & d_we;
                    f3_d    = d_req ? d_funct3 : F3_W;
                    wdata_d = d_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The _d operands are the live request when accepting straight into RESP,
    // otherwise the latched one, so the access always uses the right operands.
    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign acc_idx    = addr_d[ADDR_W-1:2];
    assign mem_we     = enter_resp && (src_d == SRC_D) && we_d && !lane_err && !rst;

    mem_lane_align u_align (
        .we_i      (we_d),
        .funct3_i  (f3_d),
        .addr_lo_i (addr_d[1:0]),
        .wdata_i   (wdata_d),
        .rword_i   (rd_word),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata),
        .err_o     (lane_err)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [DEPTH];

        always_ff @(posedge clk) begin
            if (mem_we && lane_be[gi]) lane_q[acc_idx] <= lane_wdata[gi*8 +: 8];
        end

        assign rd_word[gi*8 +: 8] = lane_q[acc_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            src_q      <= SRC_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            wdata_q  <= wdata_d;
            if_ack_q <= enter_resp && (src_d == SRC_IF);
            d_ack_q  <= enter_resp && (src_d == SRC_D);
            d_err_q  <= enter_resp && (src_d == SRC_D) && lane_err;
            if (enter_resp && (src_d == SRC_IF)) if_rdata_q <= rd_word;
            if (enter_resp && (src_d == SRC_D) && (lane_err || !we_d)) d_rdata_q <= lane_rdata;
        end
    end

    assign if_ack   = if_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Scoreboard bench for unified_mem_responder: three instances (1, 0 and 15 wait
// states) driven through req/ack transactions and checked against a reference model.
module tb_unified_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req_s   [3];
    logic [31:0] if_addr_s  [3];
    logic        if_ack_s   [3];
    logic [31:0] if_rdata_s [3];
    logic        d_req_s    [3];
    logic        d_we_s     [3];
    logic [2:0]  d_f3_s     [3];
    logic [31:0] d_addr_s   [3];
    logic [31:0] d_wdata_s  [3];
    logic        d_ack_s    [3];
    logic [31:0] d_rdata_s  [3];
    logic        d_err_s    [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int WC = (gi == 0) ? 1 : ((gi == 1) ? 0 : 15);
        unified_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(WC)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req_s[gi]),
            .if_addr  (if_addr_s[gi]),
            .if_ack   (if_ack_s[gi]),
            .if_rdata (if_rdata_s[gi]),
            .d_req    (d_req_s[gi]),
            .d_we     (d_we_s[gi]),
            .d_funct3 (d_f3_s[gi]),
            .d_addr   (d_addr_s[gi]),
            .d_wdata  (d_wdata_s[gi]),
            .d_ack    (d_ack_s[gi]),
            .d_rdata  (d_rdata_s[gi]),
            .d_err    (d_err_s[gi])
        );
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [int];
    logic [31:0] last_d [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int wc_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
    endfunction

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(bit we, logic [2:0] f3, logic [1:0] a);
        if (we) begin
            case (f3)
                3'b000:  return 1'b0;
                3'b001:  return a[0];
                3'b010:  return a != 2'b00;
                default: return 1'b1;
            endcase
        end
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return a != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] w, logic [2:0] f3, logic [1:0] a, logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (f3)
            3'b000:  r[int'(a) * 8 +: 8] = d[7:0];
            3'b001:  if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f3, logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(a) * 8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic do_xact(int k, bit fetch, bit we, logic [2:0] f3, logic [31:0] addr,
                           logic [31:0] wdata, string tag);
        exp_t        e;
        exp_t        x;
        int          key;
        logic [31:0] w;
        int          cyc;
        bit          seen;
        key = k * 4096 + int'(addr[11:2]);
        w   = mdl.exists(key) ? mdl[key] : 32'h0;
        e.lat = wc_of(k) + 1;
        if (fetch) begin
            e.rdata = w;
            e.err   = 1'b0;
        end else begin
            e.err = ref_err(we, f3, addr[1:0]);
            if (e.err) e.rdata = 32'h0;
            else if (we) begin
                e.rdata  = last_d[k];
                mdl[key] = ref_store(w, f3, addr[1:0], wdata);
            end else e.rdata = ref_load(w, f3, addr[1:0]);
            last_d[k] = e.rdata;
        end
        sb.push_back(e);

        @(negedge clk);
        if (fetch) begin
            if_req_s[k]  = 1'b1;
            if_addr_s[k] = addr;
        end else begin
            d_req_s[k]   = 1'b1;
            d_we_s[k]    = we;
            d_f3_s[k]    = f3;
            d_addr_s[k]  = addr;
            d_wdata_s[k] = wdata;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = fetch ? if_ack_s[k] : d_ack_s[k];
        end
        if_req_s[k] = 1'b0;
        d_req_s[k]  = 1'b0;

        x = sb.pop_front();
        check_val({tag, " ack"}, 32'(seen), 32'd1);
        check_val({tag, " latency"}, 32'(cyc), 32'(x.lat));
        check_val({tag, " rdata"}, fetch ? if_rdata_s[k] : d_rdata_s[k], x.rdata);
        check_val({tag, " err"}, 32'(d_err_s[k]), 32'(x.err));
        $display("xact inst=%0d %-14s addr=%h lat=%0d rdata=%h err=%0b",
                 k, tag, addr, cyc, fetch ? if_rdata_s[k] : d_rdata_s[k], d_err_s[k]);
        @(posedge clk);
        #1;
        if (seen) check_val({tag, " ack pulse"}, 32'(fetch ? if_ack_s[k] : d_ack_s[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_d;
        int   t_i;
        int   cyc;
        bit   ack_seen;
        exp_t e;
        exp_t x;

        for (int k = 0; k < 3; k++) begin
            if_req_s[k]  = 1'b0;
            if_addr_s[k] = '0;
            d_req_s[k]   = 1'b0;
            d_we_s[k]    = 1'b0;
            d_f3_s[k]    = '0;
            d_addr_s[k]  = '0;
            d_wdata_s[k] = '0;
            last_d[k]    = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset if_ack", 32'(if_ack_s[0]), 32'd0);
        check_val("reset d_ack", 32'(d_ack_s[0]), 32'd0);
        check_val("reset d_err", 32'(d_err_s[0]), 32'd0);
        check_val("reset if_rdata", if_rdata_s[0], 32'h0);
        check_val("reset d_rdata", d_rdata_s[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fetch with ignored low address bits.
        do_xact(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "sw 0x10");
        do_xact(0, 1, 0, 3'b010, 32'h13, 32'h0, "fetch 0x13");

        // Byte store and byte/word loads.
        do_xact(0, 0, 1, 3'b010, 32'h20, 32'h0, "sw 0x20");
        do_xact(0, 0, 1, 3'b000, 32'h21, 32'h000000A5, "sb 0x21");
        do_xact(0, 0, 0, 3'b000, 32'h21, 32'h0, "lb 0x21");
        do_xact(0, 0, 0, 3'b100, 32'h21, 32'h0, "lbu 0x21");
        do_xact(0, 0, 0, 3'b010, 32'h20, 32'h0, "lw 0x20");

        // Half store to the upper lane, lower half must survive.
        do_xact(0, 0, 1, 3'b010, 32'h30, 32'h12345678, "sw 0x30");
        do_xact(0, 0, 1, 3'b001, 32'h32, 32'h00008001, "sh 0x32");
        do_xact(0, 0, 0, 3'b001, 32'h32, 32'h0, "lh 0x32");
        do_xact(0, 0, 0, 3'b101, 32'h32, 32'h0, "lhu 0x32");
        do_xact(0, 0, 0, 3'b010, 32'h30, 32'h0, "lw 0x30");

        // Misaligned and illegal accesses leave memory untouched.
        do_xact(0, 0, 1, 3'b010, 32'h40, 32'h11223344, "sw 0x40");
        do_xact(0, 0, 0, 3'b000, 32'h43, 32'h0, "lb 0x43");
        do_xact(0, 0, 1, 3'b010, 32'h42, 32'hFFFFFFFF, "sw 0x42 bad");
        do_xact(0, 0, 0, 3'b001, 32'h41, 32'h0, "lh 0x41 bad");
        do_xact(0, 0, 0, 3'b011, 32'h40, 32'h0, "ld f3=011 bad");
        do_xact(0, 0, 1, 3'b100, 32'h40, 32'hFFFFFFFF, "st f3=100 bad");
        do_xact(0, 0, 0, 3'b010, 32'h40, 32'h0, "lw 0x40");

        // Simultaneous requests: data wins, fetch follows after the IDLE return.
        do_xact(0, 0, 1, 3'b010, 32'h50, 32'hCAFEF00D, "sw 0x50");
        e.rdata = 32'hCAFEF00D; e.err = 1'b0; e.lat = 2;
        sb.push_back(e);
        e.lat = 2 + wc_of(0) + 2;
        sb.push_back(e);
        last_d[0] = 32'hCAFEF00D;
        @(negedge clk);
        d_req_s[0] = 1'b1; d_we_s[0] = 1'b0; d_f3_s[0] = 3'b010; d_addr_s[0] = 32'h50;
        if_req_s[0] = 1'b1; if_addr_s[0] = 32'h50;
        cyc = 0; t_d = -1; t_i = -1;
        while (t_i < 0 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (d_ack_s[0] && t_d < 0) begin
                t_d = cyc;
                d_req_s[0] = 1'b0;
                x = sb.pop_front();
                check_val("arb data latency", 32'(t_d), 32'(x.lat));
                check_val("arb data rdata", d_rdata_s[0], x.rdata);
            end
            if (if_ack_s[0]) begin
                t_i = cyc;
                if_req_s[0] = 1'b0;
                check_val("arb data before fetch", 32'(t_d > 0), 32'd1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    check_val("arb fetch latency", 32'(t_i), 32'(x.lat));
                    check_val("arb fetch rdata", if_rdata_s[0], x.rdata);
                end
            end
        end
        d_req_s[0] = 1'b0;
        if_req_s[0] = 1'b0;
        check_val("arb fetch ack seen", 32'(t_i > 0), 32'd1);
        $display("xact inst=0 arb            d_ack@%0d if_ack@%0d", t_d, t_i);
        sb.delete();
        @(posedge clk);
        #1;

        // Reset during WAIT discards the latched store.
        do_xact(0, 0, 1, 3'b010, 32'h60, 32'h0BADF00D, "sw 0x60");
        @(negedge clk);
        d_req_s[0] = 1'b1; d_we_s[0] = 1'b1; d_f3_s[0] = 3'b010;
        d_addr_s[0] = 32'h60; d_wdata_s[0] = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            ack_seen |= d_ack_s[0];
        end
        @(negedge clk);
        d_req_s[0] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) last_d[k] = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            ack_seen |= d_ack_s[0];
        end
        check_val("midreset no ack", 32'(ack_seen), 32'd0);
        check_val("midreset if_ack", 32'(if_ack_s[0]), 32'd0);
        check_val("midreset d_err", 32'(d_err_s[0]), 32'd0);
        check_val("midreset if_rdata", if_rdata_s[0], 32'h0);
        check_val("midreset d_rdata", d_rdata_s[0], 32'h0);
        $display("xact inst=0 midreset       ack_seen=%0b", ack_seen);
        do_xact(0, 0, 0, 3'b010, 32'h60, 32'h0, "lw 0x60");

        // Wait-state extremes and address wrap.
        do_xact(1, 0, 1, 3'b010, 32'h1000, 32'h5A5A1234, "w0 sw 0x1000");
        do_xact(1, 0, 0, 3'b010, 32'h0, 32'h0, "w0 lw 0x0");
        do_xact(1, 1, 0, 3'b010, 32'h1002, 32'h0, "w0 fetch");
        do_xact(1, 0, 0, 3'b000, 32'h1003, 32'h0, "w0 lb 0x1003");
        do_xact(2, 0, 1, 3'b010, 32'h0, 32'h600DCAFE, "w15 sw 0x0");
        do_xact(2, 1, 0, 3'b010, 32'h1000, 32'h0, "w15 fetch");
        do_xact(2, 0, 0, 3'b101, 32'h1002, 32'h0, "w15 lhu");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
